// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module      : inst_fetch_if
// Description : Fetch-stage bus bundle: memory-controller IF port and the
//               decoder-facing output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_if;
    logic [31:0] if_to_mc_PC;
    logic        if_to_mc_ready;
    logic [31:0] mc_to_if_inst;
    logic        mc_to_if_ready;
    logic        dec_ready;
    logic        if_to_dec_valid;
    logic [31:0] if_to_dec_inst;
    logic [31:0] if_to_dec_pc;

    modport master (
        output if_to_mc_PC, if_to_mc_ready,
        input  mc_to_if_inst, mc_to_if_ready,
        input  dec_ready,
        output if_to_dec_valid, if_to_dec_inst, if_to_dec_pc
    );

    modport slave (
        input  if_to_mc_PC, if_to_mc_ready,
        output mc_to_if_inst, mc_to_if_ready,
        output dec_ready,
        input  if_to_dec_valid, if_to_dec_inst, if_to_dec_pc
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage with a direct-mapped one-word-line
//               instruction cache and a single-entry decoder output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter int          ICACHE_IDX = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire         clk_in,
    input  wire         rst_in,
    input  wire         rdy_in,
    input  wire         clr_in,
    input  wire  [31:0] jump_pc,
    inst_fetch_if.master bus
);

    localparam int c_DEPTH = 1 << ICACHE_IDX;
    localparam int c_TAG_W = 30 - ICACHE_IDX;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_mc_pc;
    logic                r_dec_valid;
    logic [31:0]         r_dec_inst;
    logic [31:0]         r_dec_pc;
    logic [c_DEPTH-1:0]  r_valid;
    logic [c_TAG_W-1:0]  r_tag  [c_DEPTH];
    logic [31:0]         r_data [c_DEPTH];

    logic [ICACHE_IDX-1:0] w_idx;
    logic [c_TAG_W-1:0]    w_tag;
    logic                  w_hit;
    logic                  w_slot_free;
    logic                  w_fill;

    assign w_idx       = r_pc[ICACHE_IDX+1:2];
    assign w_tag       = r_pc[31:ICACHE_IDX+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_slot_free = !r_dec_valid || bus.dec_ready;
    // A returning word coinciding with a flush is dropped, never written.
    assign w_fill      = !rst_in && !clr_in && rdy_in &&
                         (r_state == ST_MISS) && bus.mc_to_if_ready;

    // Dropped in the pulse cycle so the controller's re-arbitration sees no request.
    assign bus.if_to_mc_ready  = (r_state == ST_MISS) && !bus.mc_to_if_ready;
    assign bus.if_to_mc_PC     = r_mc_pc;
    assign bus.if_to_dec_valid = r_dec_valid;
    assign bus.if_to_dec_inst  = r_dec_inst;
    assign bus.if_to_dec_pc    = r_dec_pc;

    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.mc_to_if_inst;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_mc_pc     <= 32'h0;
            r_dec_valid <= 1'b0;
            r_dec_inst  <= 32'h0;
            r_dec_pc    <= 32'h0;
            r_valid     <= '0;
        end else if (clr_in) begin
            r_pc        <= jump_pc & 32'hFFFF_FFFC;
            r_state     <= ST_RUN;
            r_dec_valid <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                ST_RUN: begin
                    if (w_hit) begin
                        if (w_slot_free) begin
                            r_dec_valid <= 1'b1;
                            r_dec_inst  <= r_data[w_idx];
                            r_dec_pc    <= r_pc;
                            r_pc        <= r_pc + 32'd4;
                        end
                    end else begin
                        r_state <= ST_MISS;
                        r_mc_pc <= r_pc;
                        if (bus.dec_ready) begin
                            r_dec_valid <= 1'b0;
                        end
                    end
                end
                ST_MISS: begin
                    if (bus.dec_ready) begin
                        r_dec_valid <= 1'b0;
                    end
                    if (bus.mc_to_if_ready) begin
                        r_valid[w_idx] <= 1'b1;
                        r_state        <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch with a memory-controller
//               responder and a program-order / cache-content reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [31:0] jump;

    always #5 clk = ~clk;

    inst_fetch_if u_bus ();

    inst_fetch #(
        .ICACHE_IDX (4),
        .RESET_PC   (32'h0)
    ) u_dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .clr_in  (clr),
        .jump_pc (jump),
        .bus     (u_bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory image: the four words named for the reset program, a unique pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            32'hC:   return 32'h0030_0193;
            default: return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
        endcase
    endfunction

    // Reference model: expected program order plus which addresses the cache holds.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] exp_pc;
    int          n_cons  = 0;
    int          n_req   = 0;
    logic [31:0] last_req = 32'h0;

    bit          mc_busy = 1'b0;
    logic [31:0] mc_addr = 32'h0;
    int          mc_cnt  = 0;
    bit          mon_pulse;
    bit          hold_mc = 1'b0;
    bit          force_pulse = 1'b0;

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    endfunction

    initial begin
        u_bus.mc_to_if_ready = 1'b0;
        u_bus.mc_to_if_inst  = 32'h0;
        forever begin
            @(negedge clk);
            mon_pulse = 1'b0;
            if (!rst && rdy && mc_busy) begin
                if (force_pulse) begin
                    mon_pulse = 1'b1;
                end else if (!hold_mc) begin
                    if (mc_cnt == 0) mon_pulse = 1'b1;
                    else             mc_cnt--;
                end
            end
            u_bus.mc_to_if_ready = mon_pulse;
            u_bus.mc_to_if_inst  = mon_pulse ? mem_word(mc_addr) : $urandom;
            #1;
            if (rst) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                exp_pc  = 32'h0;
                mc_busy = 1'b0;
            end else begin
                if (mon_pulse) chk("no_req_in_pulse", {31'h0, u_bus.if_to_mc_ready}, 32'h0);
                if (clr) begin
                    exp_pc  = {jump[31:2], 2'b00};
                    mc_busy = 1'b0;
                end else if (rdy) begin
                    if (u_bus.if_to_dec_valid && u_bus.dec_ready) begin
                        chk("dec_pc", u_bus.if_to_dec_pc, exp_pc);
                        chk("dec_inst", u_bus.if_to_dec_inst, mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        n_cons++;
                    end
                    if (mon_pulse) begin
                        m_valid[mc_addr[5:2]] = 1'b1;
                        m_tag[mc_addr[5:2]]   = mc_addr[31:6];
                        mc_busy = 1'b0;
                    end else if (!mc_busy && u_bus.if_to_mc_ready) begin
                        chk("req_is_miss", {31'h0, m_hit(u_bus.if_to_mc_PC)}, 32'h0);
                        mc_busy  = 1'b1;
                        mc_addr  = u_bus.if_to_mc_PC;
                        mc_cnt   = $urandom_range(0, 3);
                        last_req = u_bus.if_to_mc_PC;
                        n_req++;
                    end
                end
            end
        end
    end

    task automatic pulse_clr(input logic [31:0] a);
        clr  = 1'b1;
        jump = a;
        @(posedge clk); #1;
        clr  = 1'b0;
    endtask

    task automatic wait_cons(input int n, input string tag);
        int snap = n_cons;
        int budget = 200;
        while (n_cons < snap + n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) chk(tag, 32'h0, 32'h1);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input string tag);
        int snap = n_req;
        int budget = 200;
        while (n_req == snap && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) chk({tag, "_timeout"}, 32'h0, 32'h1);
        else             chk(tag, last_req, exp_addr);
    endtask

    initial begin
        int c0, r0;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; jump = 32'h0;
        u_bus.dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, u_bus.if_to_dec_valid}, 32'h0);
        chk("rst_inst", u_bus.if_to_dec_inst, 32'h0);
        chk("rst_pc", u_bus.if_to_dec_pc, 32'h0);
        chk("rst_mc_pc", u_bus.if_to_mc_PC, 32'h0);
        chk("rst_mc_ready", {31'h0, u_bus.if_to_mc_ready}, 32'h0);
        rst = 1'b0;
        u_bus.dec_ready = 1'b1;

        // Cold start: four misses deliver the program in order.
        wait_cons(4, "t1_timeout");
        chk("t1_req_count", n_req, 32'd4);

        // Warm restart: four hits on consecutive cycles, no memory traffic.
        pulse_clr(32'h0);
        c0 = n_cons; r0 = n_req;
        repeat (5) begin @(posedge clk); #1; end
        chk("t2_hits", n_cons - c0, 32'd4);
        chk("t2_no_req", n_req - r0, 32'd0);

        // Conflict: 0x40 evicts line 0, so 0x0 must be refetched.
        pulse_clr(32'h40);
        wait_cons(1, "t3_cons_timeout");
        pulse_clr(32'h0);
        wait_req(32'h0, "t3_refill_0");
        wait_cons(1, "t3_cons0_timeout");

        // Decoder stall on a hit: output held, then resumes without loss.
        pulse_clr(32'h0);
        @(posedge clk); #1;
        u_bus.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'h0, u_bus.if_to_dec_valid}, 32'h1);
            chk("t4_hold_pc", u_bus.if_to_dec_pc, 32'h0);
            chk("t4_hold_inst", u_bus.if_to_dec_inst, 32'h0000_0013);
            @(posedge clk); #1;
        end
        u_bus.dec_ready = 1'b1;
        wait_cons(2, "t4_resume_timeout");

        // Redirect coinciding with the fill pulse discards the word.
        hold_mc = 1'b1;
        pulse_clr(32'h20);
        wait_req(32'h20, "t5_req_20");
        clr = 1'b1; jump = 32'h100; force_pulse = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; force_pulse = 1'b0;
        chk("t5_valid_cleared", {31'h0, u_bus.if_to_dec_valid}, 32'h0);
        wait_req(32'h100, "t5_next_req");
        hold_mc = 1'b0;
        wait_cons(1, "t5_cons_timeout");
        pulse_clr(32'h20);
        wait_req(32'h20, "t5_not_written");

        // Random traffic: stalls, redirects (including near the wrap point), decoder backpressure.
        c0 = n_cons;
        for (int i = 0; i < 3000; i++) begin
            rdy             = ($urandom % 10) != 0;
            u_bus.dec_ready = ($urandom % 4) != 0;
            clr             = ($urandom % 40) == 0;
            if (($urandom % 8) == 0) jump = 32'hFFFF_FFF0 + (($urandom % 4) << 2) + ($urandom % 4);
            else                     jump = ($urandom_range(0, 511) << 2) | ($urandom % 4);
            @(posedge clk); #1;
        end
        clr = 1'b0; rdy = 1'b1;
        chk("rand_progress", {31'h0, (n_cons - c0) > 200}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
